// File: rtl/uart_pkt_framer.sv
// Packet framer: pops PKT_WORDS words from a sample FIFO, serialises each word
// into bytes for a byte-wide UART transmitter, and wraps the packet with a
// cmd/~cmd header and a ~cmd/cmd trailer for the host debug assistant.
module uart_pkt_framer #(
    parameter int         DATA_W    = 16,
    parameter int         PKT_WORDS = 8,
    parameter logic [7:0] MODE_DEF  = 8'h01,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic              en,
    input  logic [7:0]        mode_in,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_req,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_busy,
    output logic              pkt_busy,
    output logic              pkt_done
);
    localparam int NB  = DATA_W / 8;
    localparam int WIW = $clog2(PKT_WORDS) + 1;
    localparam logic [WIW-1:0] LAST_WORD = WIW'(PKT_WORDS - 1);
    localparam logic [2:0]     LAST_BYTE = 3'(NB - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_LATCH, S_DATA, S_TRL} state_t;
    typedef enum logic [1:0] {P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_t;

    state_t             state, state_n;
    phase_t             phase, phase_n;
    logic [2:0]         byte_cnt, byte_cnt_n;
    logic [WIW-1:0]     word_idx, word_idx_n;
    logic [7:0]         cmd, cmd_sel, cur_byte;
    logic [DATA_W-1:0]  shreg;
    logic               tx_req_n, pkt_done_n, tx_load;
    logic               cmd_load, sh_load, sh_shift, last_byte;

    assign cmd_sel  = (mode_in == 8'd0) ? MODE_DEF : mode_in;
    assign pkt_busy = (state != S_IDLE);

    // Control state, counters and the registered UART-facing outputs.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            phase    <= P_ISSUE;
            byte_cnt <= '0;
            word_idx <= '0;
            tx_req   <= 1'b0;
            tx_data  <= 8'hFF;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            byte_cnt <= byte_cnt_n;
            word_idx <= word_idx_n;
            tx_req   <= tx_req_n;
            pkt_done <= pkt_done_n;
            if (tx_load) begin
                tx_data <= cur_byte;
            end
        end
    end

    // Latched packet command and the word being serialised; pure datapath.
    always_ff @(posedge SYS_CLK) begin
        if (cmd_load) begin
            cmd <= cmd_sel;
        end
        if (sh_load) begin
            shreg <= fifo_rd_data;
        end else if (sh_shift) begin
            shreg <= LSB_FIRST ? (shreg >> 8) : (shreg << 8);
        end
    end

    // Select the byte to send: header/trailer command bytes or next word byte.
    always_comb begin
        cur_byte = LSB_FIRST ? shreg[7:0] : shreg[DATA_W-1 -: 8];
        if (state == S_HDR) begin
            cur_byte = byte_cnt[0] ? ~cmd : cmd;
        end else if (state == S_TRL) begin
            cur_byte = byte_cnt[0] ? cmd : ~cmd;
        end
    end

    // Next-state logic: packet sequencing plus the per-byte issue/wait handshake.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        byte_cnt_n  = byte_cnt;
        word_idx_n  = word_idx;
        tx_req_n    = 1'b0;
        tx_load     = 1'b0;
        pkt_done_n  = 1'b0;
        cmd_load    = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        fifo_rd_req = 1'b0;
        last_byte   = (state == S_DATA) ? (byte_cnt == LAST_BYTE) : (byte_cnt == 3'd1);
        case (state)
            S_IDLE: begin
                if (en && !fifo_empty) begin
                    state_n    = S_HDR;
                    phase_n    = P_ISSUE;
                    byte_cnt_n = '0;
                    word_idx_n = '0;
                    cmd_load   = 1'b1;
                end
            end
            S_FETCH: begin
                // An empty FIFO mid-packet simply stalls here.
                if (!fifo_empty) begin
                    fifo_rd_req = 1'b1;
                    state_n     = S_LATCH;
                end
            end
            S_LATCH: begin
                sh_load    = 1'b1;
                state_n    = S_DATA;
                phase_n    = P_ISSUE;
                byte_cnt_n = '0;
            end
            S_HDR, S_DATA, S_TRL: begin
                case (phase)
                    P_ISSUE: begin
                        if (!tx_busy) begin
                            tx_load  = 1'b1;
                            tx_req_n = 1'b1;
                            sh_shift = (state == S_DATA);
                            phase_n  = P_WAIT_HI;
                        end
                    end
                    P_WAIT_HI: begin
                        if (tx_busy) begin
                            phase_n = P_WAIT_LO;
                        end
                    end
                    default: begin
                        if (!tx_busy) begin
                            phase_n = P_ISSUE;
                            if (!last_byte) begin
                                byte_cnt_n = byte_cnt + 3'd1;
                            end else begin
                                byte_cnt_n = '0;
                                if (state == S_HDR) begin
                                    state_n = S_FETCH;
                                end else if (state == S_TRL) begin
                                    state_n    = S_IDLE;
                                    pkt_done_n = 1'b1;
                                end else if (word_idx == LAST_WORD) begin
                                    state_n = S_TRL;
                                end else begin
                                    word_idx_n = word_idx + WIW'(1);
                                    state_n    = S_FETCH;
                                end
                            end
                        end
                    end
                endcase
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule
